// File: rtl/arith_wide_seq.sv
// arith_wide_seq: 32-bit add/sub/inc/dec sequenced as two 16-bit passes through an external ALU
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake; req_op, req_a, req_b carry the operation
//   alu_a/alu_b/alu_code/alu_cin drive to the 16-bit arithmetic unit
//   alu_c/alu_vout/alu_cout      results from the 16-bit arithmetic unit
//   resp_valid/resp_ready        response handshake; resp_c, resp_v, resp_cout, resp_err carry the result
//   ovf_count                    saturating count of delivered responses with resp_v=1
module arith_wide_seq #(
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [31:0]          req_a,
    input  logic [31:0]          req_b,
    output logic [15:0]          alu_a,
    output logic [15:0]          alu_b,
    output logic [2:0]           alu_code,
    output logic                 alu_cin,
    input  logic [15:0]          alu_c,
    input  logic                 alu_vout,
    input  logic                 alu_cout,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_c,
    output logic                 resp_v,
    output logic                 resp_cout,
    output logic                 resp_err,
    output logic [OVF_CNT_W-1:0] ovf_count
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;
    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [31:0]            opa_q, opa_d, opb_q, opb_d;
    logic                   cin0_q, cin0_d;
    logic [15:0]            lo_q, lo_d;
    logic                   carry_q, carry_d;
    logic [31:0]            resp_c_q, resp_c_d;
    logic                   resp_v_q, resp_v_d;
    logic                   resp_cout_q, resp_cout_d;
    logic                   resp_err_q, resp_err_d;
    logic [OVF_CNT_W-1:0]   ovf_q, ovf_d;
    logic                   signed_op, legal;
    // sadd/ssub/sinc/sdec are signed; only uadd (001) and usub (011) are unsigned
    assign signed_op  = op_q[2] | ~op_q[0];
    assign legal      = ~(req_op[2] & req_op[1]);
    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = (state_q == RESP);
    assign resp_c     = resp_c_q;
    assign resp_v     = resp_v_q;
    assign resp_cout  = resp_cout_q;
    assign resp_err   = resp_err_q;
    assign ovf_count  = ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            cin0_q      <= 1'b0;
            lo_q        <= '0;
            carry_q     <= 1'b0;
            resp_c_q    <= '0;
            resp_v_q    <= 1'b0;
            resp_cout_q <= 1'b0;
            resp_err_q  <= 1'b0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cin0_q      <= cin0_d;
            lo_q        <= lo_d;
            carry_q     <= carry_d;
            resp_c_q    <= resp_c_d;
            resp_v_q    <= resp_v_d;
            resp_cout_q <= resp_cout_d;
            resp_err_q  <= resp_err_d;
            ovf_q       <= ovf_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        cin0_d      = cin0_q;
        lo_d        = lo_q;
        carry_d     = carry_q;
        resp_c_d    = resp_c_q;
        resp_v_d    = resp_v_q;
        resp_cout_d = resp_cout_q;
        resp_err_d  = resp_err_q;
        ovf_d       = ovf_q;
        alu_a       = '0;
        alu_b       = '0;
        alu_code    = 3'b001;
        alu_cin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && legal) begin
                    op_d    = req_op;
                    opa_d   = req_a;
                    // subtract is A + ~B + 1; inc/dec add the constants +1 / -1
                    opb_d   = req_op[2] ? (req_op[0] ? 32'hFFFF_FFFF : 32'h0000_0001)
                                        : (req_op[1] ? ~req_b : req_b);
                    cin0_d  = ~req_op[2] & req_op[1];
                    state_d = LO;
                end else if (req_valid) begin
                    resp_c_d    = '0;
                    resp_v_d    = 1'b0;
                    resp_cout_d = 1'b0;
                    resp_err_d  = 1'b1;
                    state_d     = RESP;
                end
            end
            LO: begin
                alu_a   = opa_q[15:0];
                alu_b   = opb_q[15:0];
                alu_cin = cin0_q;
                lo_d    = alu_c;
                carry_d = alu_cout;
                state_d = HI;
            end
            HI: begin
                alu_a       = opa_q[31:16];
                alu_b       = opb_q[31:16];
                alu_cin     = carry_q;
                alu_code    = signed_op ? 3'b000 : 3'b001;
                resp_c_d    = {alu_c, lo_q};
                resp_v_d    = signed_op & alu_vout;
                // usub reports borrow, which is the inverted carry of A + ~B + 1
                resp_cout_d = signed_op ? 1'b0 : (op_q[1] ? ~alu_cout : alu_cout);
                resp_err_d  = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    ovf_d   = (resp_v_q && !(&ovf_q)) ? ovf_q + 1'b1 : ovf_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_arith_wide_seq.sv
// tb_arith_wide_seq: directed vector bench for arith_wide_seq with a behavioural 16-bit ALU
module tb_arith_wide_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_code;
    logic        alu_cin, alu_vout, alu_cout;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_c;
    logic        resp_v, resp_cout, resp_err;
    logic [7:0]  ovf_count;
    logic [16:0] sum;
    int          n_chk = 0, n_pass = 0;
    logic [7:0]  exp_ovf = '0;

    arith_wide_seq #(.OVF_CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code), .alu_cin(alu_cin),
        .alu_c(alu_c), .alu_vout(alu_vout), .alu_cout(alu_cout),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_c(resp_c), .resp_v(resp_v),
        .resp_cout(resp_cout), .resp_err(resp_err), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    // 16-bit unit: 000 signed add (vout valid), 001 unsigned add; other codes give junk
    always_comb begin
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {16'b0, alu_cin};
        alu_c    = (alu_code == 3'b000 || alu_code == 3'b001) ? sum[15:0] : 16'hDEAD;
        alu_cout = sum[16];
        alu_vout = (alu_code == 3'b000) && (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, c;
        logic        v, co, err, hcin;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_op(input vec_t t);
        int   lat;
        logic hc;
        hc = 1'b0;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = t.op; req_a = t.a; req_b = t.b;
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            if (lat == 1) chk("req_ready_busy", req_ready, 0);
            if (lat == 2) hc = alu_cin;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, t.err ? 1 : 3);
        chk("resp_c", resp_c, t.c);
        chk("resp_v", resp_v, t.v);
        chk("resp_cout", resp_cout, t.co);
        chk("resp_err", resp_err, t.err);
        if (!t.err) chk("hi_cin", hc, t.hcin);
        if (t.v && exp_ovf != 8'hFF) exp_ovf = exp_ovf + 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("valid_drop", resp_valid, 0);
        chk("ovf_count", ovf_count, exp_ovf);
    endtask

    initial begin
        tv[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[1]  = '{3'b001, 32'hFFFF0001, 32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[2]  = '{3'b011, 32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{3'b011, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[4]  = '{3'b101, 32'h80000000, 32'hDEADBEEF, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{3'b100, 32'h0000FFFF, 32'hDEADBEEF, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[6]  = '{3'b010, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{3'b010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[9]  = '{3'b001, 32'h12345678, 32'h9ABCDEF0, 32'hACF13568, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[10] = '{3'b110, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[11] = '{3'b111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_c", resp_c, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_ovf", ovf_count, 0);
        chk("rst_alu_code", alu_code, 3'b001);
        chk("rst_alu_a", alu_a, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 1);

        for (int i = 0; i < 12; i++) run_op(tv[i]);

        // backpressure: response held five cycles, a request pulse inside is ignored
        req_valid = 1'b1; req_op = 3'b000; req_a = 32'h1; req_b = 32'h2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", resp_valid, 1);
            chk("bp_c", resp_c, 32'h3);
            chk("bp_v", resp_v, 0);
            chk("bp_ready", req_ready, 0);
            req_valid = (i == 2); req_op = 3'b001; req_a = 32'h5; req_b = 32'h5;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("bp_no_extra", resp_valid, 0);
        chk("bp_idle_ready", req_ready, 1);
        chk("bp_ovf", ovf_count, exp_ovf);

        // reset during HI
        req_valid = 1'b1; req_op = 3'b000; req_a = 32'h7FFFFFFF; req_b = 32'h1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("hi_code_signed", alu_code, 3'b000);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_ovf", ovf_count, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_cin", alu_cin, 0);
        chk("mid_rst_resp_c", resp_c, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ovf = '0;
        #1;
        chk("rel_rst_ready", req_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("rel_rst_no_resp", resp_valid, 0);

        // ovf_count saturation
        for (int i = 0; i < 260; i++) run_op(tv[0]);
        chk("ovf_saturated", ovf_count, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
